// File: rtl/udp_echo_pkg.sv
// Shared types and default sizing for the UDP payload echo buffer.
// Holds the FSM encoding so the top and any monitors agree on state values.
package udp_echo_pkg;

    localparam int DEPTH_DEF = 2048;
    localparam int AW_DEF    = 11;

    typedef enum logic [2:0] {
        IDLE,
        RX,
        WAIT_TX,
        START,
        SEND
    } state_e;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port byte RAM: one write port, one registered read port.
// Read data holds its value on cycles without a read enable.
module sdp_ram #(
    parameter int DEPTH = 2048,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/udp_echo_buf.sv
// Buffers one received UDP payload, checks its length, and echoes it back
// byte-by-byte to the transmit path on request.
module udp_echo_buf
    import udp_echo_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        udp_rx_data_vld,
    input  logic [7:0]  udp_rx_data,
    input  logic        udp_rx_done,
    input  logic [15:0] udp_rx_data_num,
    input  logic        tx_rdy,
    input  logic        udp_tx_req,
    output logic        udp_tx_en,
    output logic [7:0]  udp_tx_data,
    output logic [15:0] udp_tx_data_num,
    output logic        busy,
    output logic [15:0] drop_cnt
);

    localparam logic [16:0] DEPTH_C = 17'(DEPTH);

    state_e      state_q;
    logic [16:0] wcnt_q;
    logic [16:0] rcnt_q;
    logic        trunc_q;
    logic        tx_en_q;
    logic        zero_q;
    logic [15:0] num_q;
    logic [15:0] drop_q;
    logic [7:0]  ram_rdata;

    logic        rx_ph;
    logic        full;
    logic        wr_en;
    logic        rd_en;
    logic        more;
    logic        trunc_d;
    logic        len_ok;
    logic        frame_end;
    logic        drop_hit;
    logic [16:0] wcnt_d;

    // A byte arriving together with done is counted before the length check.
    assign rx_ph     = (state_q == IDLE) || (state_q == RX);
    assign full      = (wcnt_q == DEPTH_C);
    assign wr_en     = rx_ph && udp_rx_data_vld && !full;
    assign wcnt_d    = wcnt_q + 17'(wr_en);
    assign trunc_d   = trunc_q || (rx_ph && udp_rx_data_vld && full);
    assign frame_end = rx_ph && udp_rx_done && (wcnt_d != '0);
    assign len_ok    = !trunc_d && (wcnt_d == {1'b0, udp_rx_data_num});
    assign more      = rcnt_q < {1'b0, num_q};
    assign rd_en     = (state_q == SEND) && udp_tx_req && more;
    assign drop_hit  = udp_rx_done && (rx_ph ? (frame_end && !len_ok) : 1'b1);

    sdp_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wcnt_q[AW-1:0]),
        .wdata_i (udp_rx_data),
        .re_i    (rd_en),
        .raddr_i (rcnt_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            trunc_q <= 1'b0;
            tx_en_q <= 1'b0;
            zero_q  <= 1'b1;
            num_q   <= '0;
            drop_q  <= '0;
        end else begin
            tx_en_q <= 1'b0;
            if (drop_hit && drop_q != 16'hFFFF) begin
                drop_q <= drop_q + 16'd1;
            end
            unique case (state_q)
                IDLE, RX: begin
                    wcnt_q  <= wcnt_d;
                    trunc_q <= trunc_d;
                    if (frame_end) begin
                        wcnt_q  <= '0;
                        trunc_q <= 1'b0;
                        if (len_ok) begin
                            num_q   <= wcnt_d[15:0];
                            state_q <= WAIT_TX;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (udp_rx_data_vld) begin
                        state_q <= RX;
                    end
                end
                WAIT_TX: begin
                    if (tx_rdy) begin
                        tx_en_q <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    rcnt_q  <= '0;
                    state_q <= SEND;
                end
                SEND: begin
                    if (rd_en) begin
                        rcnt_q <= rcnt_q + 17'd1;
                        zero_q <= 1'b0;
                    end else if (udp_tx_req) begin
                        zero_q <= 1'b1;
                    end
                    // Last byte has been on the bus for one cycle.
                    if (!more) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign udp_tx_en       = tx_en_q;
    assign udp_tx_data     = zero_q ? 8'h00 : ram_rdata;
    assign udp_tx_data_num = num_q;
    assign busy            = (state_q != IDLE);
    assign drop_cnt        = drop_q;

endmodule

// File: tb/tb_udp_echo_buf.sv
// Directed self-checking bench for udp_echo_buf.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_udp_echo_buf;

    logic        clk;
    logic        rst_n;
    logic        udp_rx_data_vld;
    logic [7:0]  udp_rx_data;
    logic        udp_rx_done;
    logic [15:0] udp_rx_data_num;
    logic        tx_rdy;
    logic        udp_tx_req;
    logic        udp_tx_en;
    logic [7:0]  udp_tx_data;
    logic [15:0] udp_tx_data_num;
    logic        busy;
    logic [15:0] drop_cnt;

    int checks;
    int errors;
    int en_cnt;
    logic [7:0] pat [0:7];
    logic [7:0] ex  [0:7];

    udp_echo_buf dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .udp_rx_data_vld (udp_rx_data_vld),
        .udp_rx_data     (udp_rx_data),
        .udp_rx_done     (udp_rx_done),
        .udp_rx_data_num (udp_rx_data_num),
        .tx_rdy          (tx_rdy),
        .udp_tx_req      (udp_tx_req),
        .udp_tx_en       (udp_tx_en),
        .udp_tx_data     (udp_tx_data),
        .udp_tx_data_num (udp_tx_data_num),
        .busy            (busy),
        .drop_cnt        (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (udp_tx_en === 1'b1) en_cnt++;
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rx_frame(input int n, input logic [15:0] num,
                            input bit done_last);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            udp_rx_data_vld = 1'b1;
            udp_rx_data     = (i < 8) ? pat[i] : i[7:0];
            udp_rx_done     = done_last && (i == n - 1);
            udp_rx_data_num = num;
        end
        if (!done_last) begin
            @(negedge clk);
            udp_rx_data_vld = 1'b0;
            udp_rx_done     = 1'b1;
            udp_rx_data_num = num;
        end
        @(negedge clk);
        udp_rx_data_vld = 1'b0;
        udp_rx_done     = 1'b0;
    endtask

    task automatic wait_en(input string name);
        int k;
        k = 0;
        while (udp_tx_en !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (udp_tx_en !== 1'b1) begin
            $display("FAIL %s tx_en timeout: got %b want 1", name, udp_tx_en);
            errors++;
        end
    endtask

    task automatic echo(input string name, input int n,
                        input logic [15:0] num, input bit extra);
        wait_en(name);
        checks++;
        if (udp_tx_data_num !== num) begin
            $display("FAIL %s tx_data_num: got %0d want %0d",
                     name, udp_tx_data_num, num);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (udp_tx_en !== 1'b0) begin
            $display("FAIL %s tx_en width: got %b want 0", name, udp_tx_en);
            errors++;
        end
        for (int i = 0; i < n; i++) begin
            udp_tx_req = 1'b1;
            @(negedge clk);
            checks++;
            if (udp_tx_data !== ex[i]) begin
                $display("FAIL %s byte%0d: got %h want %h",
                         name, i, udp_tx_data, ex[i]);
                errors++;
            end
        end
        udp_tx_req = extra;
        @(negedge clk);
        udp_tx_req = 1'b0;
        checks++;
        if (udp_tx_data !== (extra ? 8'h00 : ex[n-1])) begin
            $display("FAIL %s tail data: got %h want %h", name,
                     udp_tx_data, extra ? 8'h00 : ex[n-1]);
            errors++;
        end
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL %s idle after send: busy %b want 0", name, busy);
            errors++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({udp_tx_en, udp_tx_data, udp_tx_data_num, busy, drop_cnt}
            !== 42'd0) begin
            $display("FAIL reset outputs: en %b data %h num %h busy %b drop %h want all 0",
                     udp_tx_en, udp_tx_data, udp_tx_data_num, busy, drop_cnt);
            errors++;
        end
    endtask

    task automatic test_basic();
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
        ex[0]  = 8'h11; ex[1]  = 8'h22; ex[2]  = 8'h33; ex[3]  = 8'h44;
        rx_frame(4, 16'd4, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            $display("FAIL basic busy: got %b want 1", busy);
            errors++;
        end
        echo("basic", 4, 16'd4, 1'b0);
        checks++;
        if (drop_cnt !== 16'd0) begin
            $display("FAIL basic drop: got %0d want 0", drop_cnt);
            errors++;
        end
    endtask

    task automatic test_len_mismatch();
        int e0;
        apply_reset();
        e0 = en_cnt;
        pat[0] = 8'h01; pat[1] = 8'h02; pat[2] = 8'h03;
        rx_frame(3, 16'd5, 1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if (drop_cnt !== 16'd1 || busy !== 1'b0 || en_cnt != e0) begin
            $display("FAIL mismatch: drop %0d busy %b en %0d want 1 0 0",
                     drop_cnt, busy, en_cnt - e0);
            errors++;
        end
    endtask

    task automatic test_truncate();
        int e0;
        apply_reset();
        e0 = en_cnt;
        rx_frame(2049, 16'd2049, 1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if (drop_cnt !== 16'd1 || busy !== 1'b0 || en_cnt != e0) begin
            $display("FAIL truncate: drop %0d busy %b en %0d want 1 0 0",
                     drop_cnt, busy, en_cnt - e0);
            errors++;
        end
    endtask

    task automatic test_zero_len();
        int e0;
        apply_reset();
        e0 = en_cnt;
        @(negedge clk);
        udp_rx_done     = 1'b1;
        udp_rx_data_num = 16'd0;
        @(negedge clk);
        udp_rx_done = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (drop_cnt !== 16'd0 || busy !== 1'b0 || en_cnt != e0) begin
            $display("FAIL zero_len: drop %0d busy %b en %0d want 0 0 0",
                     drop_cnt, busy, en_cnt - e0);
            errors++;
        end
    endtask

    task automatic test_wait_tx();
        int e0;
        apply_reset();
        tx_rdy = 1'b0;
        e0 = en_cnt;
        pat[0] = 8'h5A; pat[1] = 8'hC3;
        ex[0]  = 8'h5A; ex[1]  = 8'hC3;
        rx_frame(2, 16'd2, 1'b0);
        pat[0] = 8'hEE; pat[1] = 8'hDD; pat[2] = 8'hCC;
        rx_frame(3, 16'd3, 1'b0);
        repeat (92) @(negedge clk);
        checks++;
        if (en_cnt != e0 || busy !== 1'b1 || drop_cnt !== 16'd1) begin
            $display("FAIL wait_tx hold: en %0d busy %b drop %0d want 0 1 1",
                     en_cnt - e0, busy, drop_cnt);
            errors++;
        end
        tx_rdy = 1'b1;
        echo("wait_tx", 2, 16'd2, 1'b0);
        checks++;
        if (drop_cnt !== 16'd1 || en_cnt != e0 + 1) begin
            $display("FAIL wait_tx end: drop %0d en %0d want 1 1",
                     drop_cnt, en_cnt - e0);
            errors++;
        end
    endtask

    task automatic test_done_with_last();
        apply_reset();
        pat[0] = 8'hA5;
        ex[0]  = 8'hA5;
        rx_frame(1, 16'd1, 1'b1);
        echo("last_done", 1, 16'd1, 1'b1);
    endtask

    task automatic test_reset_in_send();
        apply_reset();
        pat[0] = 8'h0A; pat[1] = 8'h0B; pat[2] = 8'h0C;
        rx_frame(3, 16'd3, 1'b0);
        wait_en("rst_send");
        @(negedge clk);
        udp_tx_req = 1'b1;
        @(negedge clk);
        udp_tx_req  = 1'b0;
        udp_rx_done = 1'b1;
        checks++;
        if (udp_tx_data !== 8'h0A) begin
            $display("FAIL rst_send byte0: got %h want 0a", udp_tx_data);
            errors++;
        end
        @(negedge clk);
        udp_rx_done = 1'b0;
        checks++;
        if (drop_cnt !== 16'd1 || busy !== 1'b1) begin
            $display("FAIL rst_send drop in send: drop %0d busy %b want 1 1",
                     drop_cnt, busy);
            errors++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || udp_tx_en !== 1'b0) begin
            $display("FAIL rst_send stays idle: busy %b en %b want 0 0",
                     busy, udp_tx_en);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        pat[0] = 8'h7E; pat[1] = 8'h81;
        ex[0]  = 8'h7E; ex[1]  = 8'h81;
        rx_frame(2, 16'd2, 1'b0);
        echo("b2b_a", 2, 16'd2, 1'b0);
        pat[0] = 8'h3C; pat[1] = 8'h96; pat[2] = 8'hFF;
        ex[0]  = 8'h3C; ex[1]  = 8'h96; ex[2]  = 8'hFF;
        rx_frame(3, 16'd3, 1'b1);
        echo("b2b_b", 3, 16'd3, 1'b0);
        checks++;
        if (drop_cnt !== 16'd0) begin
            $display("FAIL b2b drop: got %0d want 0", drop_cnt);
            errors++;
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        en_cnt          = 0;
        rst_n           = 1'b0;
        udp_rx_data_vld = 1'b0;
        udp_rx_data     = 8'h00;
        udp_rx_done     = 1'b0;
        udp_rx_data_num = 16'd0;
        tx_rdy          = 1'b1;
        udp_tx_req      = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_len_mismatch();
        test_truncate();
        test_zero_len();
        test_wait_tx();
        test_done_with_last();
        test_reset_in_send();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
